mxu_scratchpad: RTL and testbench
=================================

// Module: mxu_scratchpad
// PURPOSE
//  Fixed-latency memory responder on the MXU side of the memory interface. It answers the
//  MXU wrapper's mem_req_addr/mem_read_en/mem_write_en/mem_req_data requests and returns
//  mem_resp_data on a deterministic schedule with no back-pressure. A second host/DMA port
//  (valid/ready) preloads W/X matrices and drains results. The MXU port has absolute priority.
// PARAMETERS
//  DATA_WIDTH      32    bits per element
//  BANKING_FACTOR  1     elements per beat; beat width BW = BANKING_FACTOR*DATA_WIDTH
//  ADDRESS_WIDTH   13    address bits; one address = one beat
//  DEPTH           1024  beats stored; an address >= DEPTH is out of range (OOR)
//  RESP_LATENCY    1     register stages from request edge to data (1..4); 1 suits initiator MEM_LATENCY=3
// PORTS
//  clk             in   1              single clock, rising edge
//  rst             in   1              asynchronous reset, active-high
//  mem_req_addr    in   ADDRESS_WIDTH  MXU beat address
//  mem_req_data    in   BW             MXU write beat
//  mem_read_en     in   1              MXU read request, one cycle per beat
//  mem_write_en    in   1              MXU write request, one cycle per beat
//  mem_resp_data   out  BW             MXU read data, held until the next MXU read completes
//  host_req_valid  in   1              host request valid
//  host_req_ready  out  1              host request accepted when valid&&ready
//  host_req_we     in   1              1 = write, 0 = read
//  host_req_addr   in   ADDRESS_WIDTH  host beat address
//  host_req_wdata  in   BW             host write beat
//  host_resp_valid out  1              one-cycle pulse with host read data
//  host_resp_data  out  BW             host read data, valid while host_resp_valid=1
// BEHAVIOUR
//  - Reset: mem_resp_data=0, host_resp_valid=0, host_resp_data=0, both read pipelines flushed.
//    host_req_ready=0 while rst=1. Array contents are not reset. A read in flight when reset
//    asserts is dropped, and no response appears after reset releases.
//  - Arbitration is combinational: host_req_ready = !rst && !mem_read_en && !mem_write_en.
//    Only one access reaches the array per cycle.
//  - Writes commit at the sampling edge. A read sampled on the next edge returns the new data.
//  - MXU read sampled at edge k: mem_resp_data is updated after edge k+RESP_LATENCY and then
//    holds that value until the next MXU read result lands. Reads can be issued back-to-back.
//  - Host read accepted at edge k: host_resp_valid=1 for exactly one cycle, after edge
//    k+RESP_LATENCY. Responses are in order, and the port handles one request per cycle.
//  - A separate valid shift register per port (depth RESP_LATENCY) tracks in-flight reads.
//    Host and MXU results never cross ports.
//  - mem_read_en && mem_write_en in the same cycle: the write is performed, the read is dropped,
//    and mem_resp_data keeps its value.
//  - OOR write: ignored. OOR read: returns all-zero data on the normal schedule.
//  - Data is opaque bits. No arithmetic on data. Address compares are unsigned at full
//    ADDRESS_WIDTH.
// CONFIGURATION
//  MXU_SCRATCHPAD_ERR_EN defined:
//    - Adds output port err_sticky (1 bit, reset 0).
//    - err_sticky sets on any OOR access from either port, or on MXU read+write in the same cycle.
//    - err_sticky clears only on rst. Data behaviour is unchanged.
//  MXU_SCRATCHPAD_ERR_EN undefined: no err_sticky port; these conditions are silent.
// TESTING
//  1. Host writes addr 0..15 = 1..16, then MXU reads addr 0..15 back-to-back
//     -> mem_resp_data = 1..16 in order, each RESP_LATENCY cycles after its request.
//  2. MXU read held high while host_req_valid=1 -> host_req_ready=0 every cycle.
//     Host request is accepted the cycle after mem_read_en drops; host_resp_valid pulses once.
//  3. MXU write addr 5=0xDEAD at edge k, MXU read addr 5 at edge k+1
//     -> mem_resp_data=0xDEAD after edge k+1+RESP_LATENCY.
//  4. Host read addr DEPTH (OOR) -> host_resp_valid pulses with data 0;
//     err_sticky=1 when MXU_SCRATCHPAD_ERR_EN is defined.
//  5. MXU read issued, rst pulsed before the data is due
//     -> mem_resp_data=0, no host_resp_valid, array contents intact on later reads.
//  6. mem_read_en=mem_write_en=1 at addr 7 with data 0x55
//     -> addr 7 reads back 0x55; mem_resp_data unchanged that cycle.

Source files
------------

// File: rtl/mxu_scratchpad.sv
// Fixed-latency scratchpad: the MXU port has absolute priority, the host valid/ready port fills the idle cycles; reads land RESP_LATENCY edges after sampling.
// Optional sticky error flag for out-of-range / read+write collisions when MXU_SCRATCHPAD_ERR_EN is defined.
module mxu_scratchpad #(
  parameter int DATA_WIDTH     = 32,
  parameter int BANKING_FACTOR = 1,
  parameter int ADDRESS_WIDTH  = 13,
  parameter int DEPTH          = 1024,
  parameter int RESP_LATENCY   = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [ADDRESS_WIDTH-1:0]               mem_req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0]   mem_req_data,
  input  logic                                   mem_read_en,
  input  logic                                   mem_write_en,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0]   mem_resp_data,
  input  logic                                   host_req_valid,
  output logic                                   host_req_ready,
  input  logic                                   host_req_we,
  input  logic [ADDRESS_WIDTH-1:0]               host_req_addr,
  input  logic [BANKING_FACTOR*DATA_WIDTH-1:0]   host_req_wdata,
  output logic                                   host_resp_valid,
  output logic [BANKING_FACTOR*DATA_WIDTH-1:0]   host_resp_data
`ifdef MXU_SCRATCHPAD_ERR_EN
  ,
  output logic                                   err_sticky
`endif
);

  localparam int BW    = BANKING_FACTOR * DATA_WIDTH;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = (ADDRESS_WIDTH + 1)'(DEPTH);

  logic                     mxu_acc, mxu_rd, host_acc, host_rd, host_wr;
  logic [ADDRESS_WIDTH-1:0] acc_addr;
  logic                     acc_in_range;
  logic [IDX_W-1:0]         acc_idx;
  logic                     wr_en, rd_en;
  logic [BW-1:0]            wr_dat;

  logic [BW-1:0]            mem_q [DEPTH];
  logic [BW-1:0]            dat_q [RESP_LATENCY];
  logic [RESP_LATENCY-1:0]  mxu_vld_q, host_vld_q;
  logic [BW-1:0]            mem_resp_q, mem_resp_d;
  logic [BW-1:0]            host_resp_q, host_resp_d;
  logic                     host_resp_vld_q;

  assign host_req_ready = !rst && !mem_read_en && !mem_write_en;

  assign mxu_acc  = mem_read_en || mem_write_en;
  // A simultaneous MXU read+write performs only the write.
  assign mxu_rd   = mem_read_en && !mem_write_en;
  assign host_acc = host_req_valid && host_req_ready;
  assign host_wr  = host_acc && host_req_we;
  assign host_rd  = host_acc && !host_req_we;

  assign acc_addr     = mxu_acc ? mem_req_addr : host_req_addr;
  assign acc_in_range = ({1'b0, acc_addr} < DEPTH_LIM);
  assign acc_idx      = acc_addr[IDX_W-1:0];
  assign wr_dat       = mxu_acc ? mem_req_data : host_req_wdata;
  assign wr_en        = (mem_write_en || host_wr) && acc_in_range;
  assign rd_en        = mxu_rd || host_rd;

  // Array and data pipeline carry no reset; only the valid bits decide what lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[acc_idx] <= wr_dat;
    end
    if (rd_en) begin
      dat_q[0] <= acc_in_range ? mem_q[acc_idx] : '0;
    end
    for (int i = 1; i < RESP_LATENCY; i++) begin
      dat_q[i] <= dat_q[i-1];
    end
  end

  always_comb begin
    mem_resp_d  = mem_resp_q;
    host_resp_d = host_resp_q;
    if (mxu_vld_q[RESP_LATENCY-1]) begin
      mem_resp_d = dat_q[RESP_LATENCY-1];
    end
    if (host_vld_q[RESP_LATENCY-1]) begin
      host_resp_d = dat_q[RESP_LATENCY-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mxu_vld_q       <= '0;
      host_vld_q      <= '0;
      mem_resp_q      <= '0;
      host_resp_q     <= '0;
      host_resp_vld_q <= 1'b0;
    end else begin
      mxu_vld_q[0]  <= mxu_rd;
      host_vld_q[0] <= host_rd;
      for (int i = 1; i < RESP_LATENCY; i++) begin
        mxu_vld_q[i]  <= mxu_vld_q[i-1];
        host_vld_q[i] <= host_vld_q[i-1];
      end
      mem_resp_q      <= mem_resp_d;
      host_resp_q     <= host_resp_d;
      host_resp_vld_q <= host_vld_q[RESP_LATENCY-1];
    end
  end

  assign mem_resp_data   = mem_resp_q;
  assign host_resp_data  = host_resp_q;
  assign host_resp_valid = host_resp_vld_q;

`ifdef MXU_SCRATCHPAD_ERR_EN
  logic err_q, err_set;

  assign err_set = ((mxu_acc || host_acc) && !acc_in_range) || (mem_read_en && mem_write_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign err_sticky = err_q;
`endif

endmodule

// File: tb/tb_mxu_scratchpad.sv
// Scoreboard bench for mxu_scratchpad: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_mxu_scratchpad;
  localparam int DW    = 32;
  localparam int AW    = 13;
  localparam int DEPTH = 1024;
  localparam int L     = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_req_addr = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic          mem_read_en = 1'b0;
  logic          mem_write_en = 1'b0;
  logic [DW-1:0] mem_resp_data;
  logic          host_req_valid = 1'b0;
  logic          host_req_ready;
  logic          host_req_we = 1'b0;
  logic [AW-1:0] host_req_addr = '0;
  logic [DW-1:0] host_req_wdata = '0;
  logic          host_resp_valid;
  logic [DW-1:0] host_resp_data;
`ifdef MXU_SCRATCHPAD_ERR_EN
  logic          err_sticky;
`endif

  mxu_scratchpad #(
    .DATA_WIDTH(DW), .BANKING_FACTOR(1), .ADDRESS_WIDTH(AW), .DEPTH(DEPTH), .RESP_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_read_en(mem_read_en), .mem_write_en(mem_write_en), .mem_resp_data(mem_resp_data),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready), .host_req_we(host_req_we),
    .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
    .host_resp_valid(host_resp_valid), .host_resp_data(host_resp_data)
`ifdef MXU_SCRATCHPAD_ERR_EN
    , .err_sticky(err_sticky)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int          due;
    logic [31:0] dat;
  } mexp_t;

  mexp_t       mq[$];
  logic [31:0] hq[$];
  logic [31:0] last_mxu = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: host responses in order, MXU results at their scheduled cycle.
  always @(negedge clk) begin
    if (host_resp_valid === 1'b1) begin
      if (hq.size() == 0) check("host_unexpected_resp", 32'd1, 32'd0);
      else check("host_resp_data", host_resp_data, hq.pop_front());
    end
    if (mq.size() != 0) begin
      if (mq[0].due == cyc) begin
        check("mxu_resp_data", mem_resp_data, mq[0].dat);
        void'(mq.pop_front());
      end else if (mq[0].due < cyc) begin
        check("mxu_resp_missed", 32'd1, 32'd0);
        void'(mq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [31:0] exp);
    host_req_valid = 1'b1;
    host_req_we    = we;
    host_req_addr  = a;
    host_req_wdata = d;
    #1;
    for (int i = 0; i < 20 && !host_req_ready; i++) step();
    check("host_req_ready", {31'd0, host_req_ready}, 32'd1);
    if (!we) hq.push_back(exp);
    step();
    host_req_valid = 1'b0;
    host_req_we    = 1'b0;
  endtask

  // Leaves mem_read_en high so consecutive calls issue back-to-back reads.
  task automatic mxu_read(input logic [AW-1:0] a, input logic [31:0] exp);
    mem_read_en  = 1'b1;
    mem_write_en = 1'b0;
    mem_req_addr = a;
    mq.push_back('{due: cyc + 1 + L, dat: exp});
    last_mxu = exp;
    step();
  endtask

  task automatic mxu_idle();
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
  endtask

  task automatic drain();
    repeat (L + 3) step();
  endtask

  initial begin
    // Reset state
    repeat (2) step();
    check("rst_mem_resp_data", mem_resp_data, 32'd0);
    check("rst_host_resp_valid", {31'd0, host_resp_valid}, 32'd0);
    check("rst_host_resp_data", host_resp_data, 32'd0);
    check("rst_host_req_ready", {31'd0, host_req_ready}, 32'd0);
`ifdef MXU_SCRATCHPAD_ERR_EN
    check("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
`endif
    rst = 1'b0;
    step();

    // 1: host preload 0..15 = 1..16, MXU reads back-to-back
    for (int i = 0; i < 16; i++) host_op(1'b1, AW'(i), 32'(i + 1), 32'd0);
    for (int i = 0; i < 16; i++) mxu_read(AW'(i), 32'(i + 1));
    mxu_idle();
    drain();

    // 2: MXU read held high blocks host; host accepted once the read drops
    host_req_valid = 1'b1;
    host_req_we    = 1'b0;
    host_req_addr  = AW'(10);
    for (int i = 0; i < 4; i++) begin
      mxu_read(AW'(i), 32'(i + 1));
      check("ready_blocked_by_mxu", {31'd0, host_req_ready}, 32'd0);
    end
    mxu_idle();
    #1;
    check("ready_after_mxu_drop", {31'd0, host_req_ready}, 32'd1);
    hq.push_back(32'd11);
    step();
    host_req_valid = 1'b0;
    drain();

    // 3: MXU write then immediate read of the same address
    mem_write_en = 1'b1;
    mem_req_addr = AW'(5);
    mem_req_data = 32'hDEAD;
    step();
    mxu_read(AW'(5), 32'hDEAD);
    mxu_idle();
    drain();

    // 4: out-of-range accesses and the last in-range beat
    host_op(1'b0, AW'(DEPTH), 32'd0, 32'd0);
    drain();
`ifdef MXU_SCRATCHPAD_ERR_EN
    check("err_after_oor", {31'd0, err_sticky}, 32'd1);
`endif
    host_op(1'b1, AW'(DEPTH + 5), 32'hBAD0BAD0, 32'd0);
    host_op(1'b1, AW'(DEPTH - 1), 32'hA5A5A5A5, 32'd0);
    mxu_read(AW'(5), 32'hDEAD);
    mxu_read(AW'(DEPTH - 1), 32'hA5A5A5A5);
    mxu_read(13'h1FFF, 32'd0);
    mxu_read(AW'(5), 32'hDEAD);
    mxu_idle();
    drain();

    // 5: reset while an MXU read is in flight, then while a host read is in flight
    mem_read_en  = 1'b1;
    mem_req_addr = AW'(2);
    step();
    mem_read_en = 1'b0;
    rst = 1'b1;
    #1;
    check("ready_during_rst", {31'd0, host_req_ready}, 32'd0);
    step();
    step();
    rst = 1'b0;
    last_mxu = 32'd0;
    @(negedge clk);
    check("mxu_flushed_by_rst", mem_resp_data, 32'd0);
    check("host_data_after_rst", host_resp_data, 32'd0);
`ifdef MXU_SCRATCHPAD_ERR_EN
    check("err_cleared_by_rst", {31'd0, err_sticky}, 32'd0);
`endif
    step();
    host_req_valid = 1'b1;
    host_req_we    = 1'b0;
    host_req_addr  = AW'(1);
    step();
    host_req_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("host_flushed_by_rst", {31'd0, host_resp_valid}, 32'd0);
    end
    step();
    mxu_read(AW'(0), 32'd1);
    mxu_read(AW'(2), 32'd3);
    mxu_read(AW'(5), 32'hDEAD);
    mxu_idle();
    drain();

    // 6: read and write together at addr 7: write wins, read data holds
    mem_read_en  = 1'b1;
    mem_write_en = 1'b1;
    mem_req_addr = AW'(7);
    mem_req_data = 32'h55;
    step();
    mxu_idle();
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      check("mxu_hold_on_rdwr", mem_resp_data, last_mxu);
    end
`ifdef MXU_SCRATCHPAD_ERR_EN
    check("err_on_rdwr", {31'd0, err_sticky}, 32'd1);
`endif
    step();
    mxu_read(AW'(7), 32'h55);
    mxu_idle();
    host_op(1'b0, AW'(7), 32'd0, 32'h55);
    drain();

    check("mxu_queue_empty", 32'(mq.size()), 32'd0);
    check("host_queue_empty", 32'(hq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
